// File: rtl/id_pipe_decoder_pkg.sv
// Shared constants for the ID stage: internal command codes, MIPS opcode/funct fields,
// default widths and the output-register state type.
package id_pipe_decoder_pkg;

  localparam int unsigned OP_LENGTH    = 6;
  localparam int unsigned REG_ADDR_LEN = 5;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [OP_LENGTH-1:0] {
    CMD_NONE = 6'd0,
    CMD_ADD  = 6'd1,
    CMD_SUB  = 6'd2,
    CMD_AND  = 6'd3,
    CMD_OR   = 6'd4,
    CMD_XOR  = 6'd5,
    CMD_SLT  = 6'd6,
    CMD_ADDI = 6'd7,
    CMD_ANDI = 6'd8,
    CMD_ORI  = 6'd9,
    CMD_XORI = 6'd10,
    CMD_SLTI = 6'd11,
    CMD_LUI  = 6'd12,
    CMD_LW   = 6'd13,
    CMD_SW   = 6'd14,
    CMD_BEQ  = 6'd15
  } cmd_e;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_SLTI    = 6'h0A;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand bypass select: EX result, then MEM result, then register file; r0 reads zero.
module id_fwd_mux #(
  parameter int unsigned REG_LENGTH   = 32,
  parameter int unsigned REG_ADDR_LEN = 5
) (
  input  logic                    rd_i,
  input  logic [REG_ADDR_LEN-1:0] addr_i,
  input  logic [REG_LENGTH-1:0]   rf_data_i,
  input  logic                    ex_wr_i,
  input  logic [REG_ADDR_LEN-1:0] ex_addr_i,
  input  logic [REG_LENGTH-1:0]   ex_data_i,
  input  logic                    mem_wr_i,
  input  logic [REG_ADDR_LEN-1:0] mem_addr_i,
  input  logic [REG_LENGTH-1:0]   mem_data_i,
  output logic [REG_LENGTH-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    if (rd_i && (addr_i != '0)) begin
      if (ex_wr_i && (ex_addr_i == addr_i)) begin
        data_o = ex_data_i;
      end else if (mem_wr_i && (mem_addr_i == addr_i)) begin
        data_o = mem_data_i;
      end else begin
        data_o = rf_data_i;
      end
    end
  end

endmodule

// File: rtl/id_pipe_decoder.sv
// Registered MIPS instruction-decode stage: decode, operand forwarding, load-use stall
// and a single-entry valid/ready output register.
module id_pipe_decoder #(
  parameter int unsigned INST_LENGTH  = 32,
  parameter int unsigned REG_LENGTH   = 32,
  parameter int unsigned REG_ADDR_LEN = id_pipe_decoder_pkg::REG_ADDR_LEN,
  parameter int unsigned OP_LENGTH    = id_pipe_decoder_pkg::OP_LENGTH,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INST_LENGTH-1:0]  inst,
  output logic                    regaRd,
  output logic                    regbRd,
  output logic [REG_ADDR_LEN-1:0] regaAddr,
  output logic [REG_ADDR_LEN-1:0] regbAddr,
  input  logic [REG_LENGTH-1:0]   regaData_i,
  input  logic [REG_LENGTH-1:0]   regbData_i,
  input  logic                    ex_wr,
  input  logic [REG_ADDR_LEN-1:0] ex_addr,
  input  logic [REG_LENGTH-1:0]   ex_data,
  input  logic                    ex_is_load,
  input  logic                    mem_wr,
  input  logic [REG_ADDR_LEN-1:0] mem_addr,
  input  logic [REG_LENGTH-1:0]   mem_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OP_LENGTH-1:0]    op,
  output logic [REG_LENGTH-1:0]   regaData,
  output logic [REG_LENGTH-1:0]   regbData,
  output logic [REG_LENGTH-1:0]   imm,
  output logic                    regcWr,
  output logic [REG_ADDR_LEN-1:0] regcAddr,
  output logic                    illegal,
  output logic [STALL_CNT_W-1:0]  stall_cnt
);

  import id_pipe_decoder_pkg::*;

  logic [5:0]              opc;
  logic [5:0]              funct;
  logic [REG_ADDR_LEN-1:0] rs;
  logic [REG_ADDR_LEN-1:0] rt;
  logic [REG_ADDR_LEN-1:0] rd;
  logic [REG_LENGTH-1:0]   imm_sx;
  logic [REG_LENGTH-1:0]   imm_zx;
  logic [REG_LENGTH-1:0]   imm_hi;
  logic                    unused_shamt;

  assign opc          = inst[31:26];
  assign funct        = inst[5:0];
  assign rs           = REG_ADDR_LEN'(inst[25:21]);
  assign rt           = REG_ADDR_LEN'(inst[20:16]);
  assign rd           = REG_ADDR_LEN'(inst[15:11]);
  assign imm_sx       = {{(REG_LENGTH-16){inst[15]}}, inst[15:0]};
  assign imm_zx       = {{(REG_LENGTH-16){1'b0}}, inst[15:0]};
  assign imm_hi       = {inst[15:0], {(REG_LENGTH-16){1'b0}}};
  assign unused_shamt = ^inst[10:6];

  logic [OP_LENGTH-1:0]    dec_op;
  logic                    dec_wr;
  logic [REG_ADDR_LEN-1:0] dec_dst;
  logic [REG_LENGTH-1:0]   dec_imm;
  logic                    dec_illegal;

  // Instruction decode; unsupported encodings become an illegal no-op slot.
  always_comb begin
    dec_op      = OP_LENGTH'(CMD_NONE);
    regaRd      = DISABLE;
    regbRd      = DISABLE;
    dec_wr      = DISABLE;
    dec_dst     = '0;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    unique case (opc)
      OPC_SPECIAL: begin
        regaRd  = ENABLE;
        regbRd  = ENABLE;
        dec_wr  = ENABLE;
        dec_dst = rd;
        unique case (funct)
          FN_ADD:  dec_op = OP_LENGTH'(CMD_ADD);
          FN_SUB:  dec_op = OP_LENGTH'(CMD_SUB);
          FN_AND:  dec_op = OP_LENGTH'(CMD_AND);
          FN_OR:   dec_op = OP_LENGTH'(CMD_OR);
          FN_XOR:  dec_op = OP_LENGTH'(CMD_XOR);
          FN_SLT:  dec_op = OP_LENGTH'(CMD_SLT);
          default: begin
            regaRd      = DISABLE;
            regbRd      = DISABLE;
            dec_wr      = DISABLE;
            dec_dst     = '0;
            dec_illegal = 1'b1;
          end
        endcase
      end
      OPC_ADDI: begin regaRd = ENABLE; dec_wr = ENABLE; dec_dst = rt; dec_imm = imm_sx; dec_op = OP_LENGTH'(CMD_ADDI); end
      OPC_SLTI: begin regaRd = ENABLE; dec_wr = ENABLE; dec_dst = rt; dec_imm = imm_sx; dec_op = OP_LENGTH'(CMD_SLTI); end
      OPC_ANDI: begin regaRd = ENABLE; dec_wr = ENABLE; dec_dst = rt; dec_imm = imm_zx; dec_op = OP_LENGTH'(CMD_ANDI); end
      OPC_ORI:  begin regaRd = ENABLE; dec_wr = ENABLE; dec_dst = rt; dec_imm = imm_zx; dec_op = OP_LENGTH'(CMD_ORI);  end
      OPC_XORI: begin regaRd = ENABLE; dec_wr = ENABLE; dec_dst = rt; dec_imm = imm_zx; dec_op = OP_LENGTH'(CMD_XORI); end
      OPC_LUI:  begin dec_wr = ENABLE; dec_dst = rt; dec_imm = imm_hi; dec_op = OP_LENGTH'(CMD_LUI); end
      OPC_LW:   begin regaRd = ENABLE; dec_wr = ENABLE; dec_dst = rt; dec_imm = imm_sx; dec_op = OP_LENGTH'(CMD_LW); end
      OPC_SW:   begin regaRd = ENABLE; regbRd = ENABLE; dec_imm = imm_sx; dec_op = OP_LENGTH'(CMD_SW); end
      OPC_BEQ:  begin regaRd = ENABLE; regbRd = ENABLE; dec_imm = imm_sx; dec_op = OP_LENGTH'(CMD_BEQ); end
      default:  dec_illegal = 1'b1;
    endcase
  end

  assign regaAddr = regaRd ? rs : '0;
  assign regbAddr = regbRd ? rt : '0;

  logic [REG_LENGTH-1:0] fwd_a;
  logic [REG_LENGTH-1:0] fwd_b;

  id_fwd_mux #(.REG_LENGTH(REG_LENGTH), .REG_ADDR_LEN(REG_ADDR_LEN)) u_fwd_a (
    .rd_i(regaRd), .addr_i(regaAddr), .rf_data_i(regaData_i),
    .ex_wr_i(ex_wr), .ex_addr_i(ex_addr), .ex_data_i(ex_data),
    .mem_wr_i(mem_wr), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .data_o(fwd_a)
  );

  id_fwd_mux #(.REG_LENGTH(REG_LENGTH), .REG_ADDR_LEN(REG_ADDR_LEN)) u_fwd_b (
    .rd_i(regbRd), .addr_i(regbAddr), .rf_data_i(regbData_i),
    .ex_wr_i(ex_wr), .ex_addr_i(ex_addr), .ex_data_i(ex_data),
    .mem_wr_i(mem_wr), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .data_o(fwd_b)
  );

  state_e                  state_q, state_d;
  logic [OP_LENGTH-1:0]    op_q, op_d;
  logic [REG_LENGTH-1:0]   rega_q, rega_d, regb_q, regb_d, imm_q, imm_d;
  logic                    wr_q, wr_d, ill_q, ill_d;
  logic [REG_ADDR_LEN-1:0] dst_q, dst_d;
  logic [STALL_CNT_W-1:0]  stall_q, stall_d;
  logic                    advance;
  logic                    hz;
  logic                    accept;

  // A load in EX cannot be bypassed; hold the consumer until it reaches MEM.
  assign hz = in_valid & ex_is_load & ex_wr & (ex_addr != '0) &
              ((regaRd & (regaAddr == ex_addr)) | (regbRd & (regbAddr == ex_addr)));

  assign advance  = (state_q == ST_EMPTY) | out_ready;
  assign in_ready = ~rst & ~hz & advance;
  assign accept   = in_valid & in_ready;

  // Output register next state: load, bubble or hold.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rega_d  = rega_q;
    regb_d  = regb_q;
    imm_d   = imm_q;
    wr_d    = wr_q;
    dst_d   = dst_q;
    ill_d   = ill_q;
    stall_d = stall_q;
    if (advance) begin
      if (accept) begin
        state_d = ST_FULL;
        op_d    = dec_op;
        rega_d  = fwd_a;
        regb_d  = fwd_b;
        imm_d   = dec_imm;
        wr_d    = dec_wr & (dec_dst != '0);
        dst_d   = dec_dst;
        ill_d   = dec_illegal;
      end else begin
        state_d = ST_EMPTY;
        op_d    = OP_LENGTH'(CMD_NONE);
        rega_d  = '0;
        regb_d  = '0;
        imm_d   = '0;
        wr_d    = 1'b0;
        dst_d   = '0;
        ill_d   = 1'b0;
      end
      if (hz && (stall_q != '1)) begin
        stall_d = stall_q + STALL_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      op_q    <= OP_LENGTH'(CMD_NONE);
      rega_q  <= '0;
      regb_q  <= '0;
      imm_q   <= '0;
      wr_q    <= 1'b0;
      dst_q   <= '0;
      ill_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      imm_q   <= imm_d;
      wr_q    <= wr_d;
      dst_q   <= dst_d;
      ill_q   <= ill_d;
      stall_q <= stall_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign op        = op_q;
  assign regaData  = rega_q;
  assign regbData  = regb_q;
  assign imm       = imm_q;
  assign regcWr    = wr_q;
  assign regcAddr  = dst_q;
  assign illegal   = ill_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_pipe_decoder.sv
// Directed bench for id_pipe_decoder: decode, forwarding, load-use stall, backpressure, reset.
module tb_id_pipe_decoder;
  import id_pipe_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic        regaRd, regbRd;
  logic [4:0]  regaAddr, regbAddr;
  logic [31:0] regaData_i, regbData_i;
  logic        ex_wr, ex_is_load, mem_wr;
  logic [4:0]  ex_addr, mem_addr;
  logic [31:0] ex_data, mem_data;
  logic        out_valid, out_ready;
  logic [5:0]  op;
  logic [31:0] regaData, regbData, imm;
  logic        regcWr;
  logic [4:0]  regcAddr;
  logic        illegal;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  id_pipe_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .regaRd(regaRd), .regbRd(regbRd), .regaAddr(regaAddr), .regbAddr(regbAddr),
    .regaData_i(regaData_i), .regbData_i(regbData_i),
    .ex_wr(ex_wr), .ex_addr(ex_addr), .ex_data(ex_data), .ex_is_load(ex_is_load),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready), .op(op),
    .regaData(regaData), .regbData(regbData), .imm(imm),
    .regcWr(regcWr), .regcAddr(regcAddr), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; inst = '0; out_ready = 1'b1;
    regaData_i = '0; regbData_i = '0;
    ex_wr = 1'b0; ex_addr = '0; ex_data = '0; ex_is_load = 1'b0;
    mem_wr = 1'b0; mem_addr = '0; mem_data = '0;
    step(); step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    n_vec++; if (op !== CMD_NONE) begin n_err++; $display("FAIL rst_op got %0d exp %0d", op, CMD_NONE); end
    n_vec++; if (regcWr !== 1'b0 || regcAddr !== 5'd0) begin n_err++; $display("FAIL rst_regc got %b/%0d exp 0/0", regcWr, regcAddr); end
    n_vec++; if (regaData !== 32'd0 || regbData !== 32'd0 || imm !== 32'd0) begin n_err++; $display("FAIL rst_data got %h %h %h exp 0", regaData, regbData, imm); end
    n_vec++; if (illegal !== 1'b0 || stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_ill_stall got %b/%0d exp 0/0", illegal, stall_cnt); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    inst = 32'h2022FFFC; in_valid = 1'b1; regaData_i = 32'd10; regbData_i = 32'd77;
    #1;
    n_vec++; if (regaRd !== 1'b1 || regaAddr !== 5'd1 || regbRd !== 1'b0 || regbAddr !== 5'd0) begin n_err++; $display("FAIL addi_rd got %b/%0d %b/%0d exp 1/1 0/0", regaRd, regaAddr, regbRd, regbAddr); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL addi_in_ready got %b exp 1", in_ready); end
    step(); in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || op !== CMD_ADDI) begin n_err++; $display("FAIL addi_op got %b/%0d exp 1/%0d", out_valid, op, CMD_ADDI); end
    n_vec++; if (regaData !== 32'd10 || regbData !== 32'd0) begin n_err++; $display("FAIL addi_data got %h/%h exp a/0", regaData, regbData); end
    n_vec++; if (imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL addi_imm got %h exp fffffffc", imm); end
    n_vec++; if (regcWr !== 1'b1 || regcAddr !== 5'd2 || illegal !== 1'b0) begin n_err++; $display("FAIL addi_regc got %b/%0d/%b exp 1/2/0", regcWr, regcAddr, illegal); end
  endtask

  task automatic test_forwarding();
    regaData_i = 32'd100; regbData_i = 32'd100;
    ex_wr = 1'b1; ex_addr = 5'd1; ex_data = 32'd7;
    mem_wr = 1'b1; mem_addr = 5'd1; mem_data = 32'd9;
    inst = 32'h00211820; in_valid = 1'b1;
    step();
    n_vec++; if (regaData !== 32'd7 || regbData !== 32'd7) begin n_err++; $display("FAIL fwd_ex got %0d/%0d exp 7/7", regaData, regbData); end
    n_vec++; if (op !== CMD_ADD || regcAddr !== 5'd3 || regcWr !== 1'b1) begin n_err++; $display("FAIL fwd_add_op got %0d/%0d/%b exp %0d/3/1", op, regcAddr, regcWr, CMD_ADD); end
    ex_wr = 1'b0;
    step();
    n_vec++; if (regaData !== 32'd9 || regbData !== 32'd9) begin n_err++; $display("FAIL fwd_mem got %0d/%0d exp 9/9", regaData, regbData); end
    mem_wr = 1'b0;
    step();
    n_vec++; if (regaData !== 32'd100 || regbData !== 32'd100) begin n_err++; $display("FAIL fwd_rf got %0d/%0d exp 100/100", regaData, regbData); end
    ex_wr = 1'b1; mem_wr = 1'b1; ex_addr = 5'd0; mem_addr = 5'd0;
    inst = 32'h00001820;
    step();
    n_vec++; if (regaData !== 32'd0 || regbData !== 32'd0) begin n_err++; $display("FAIL fwd_r0 got %0d/%0d exp 0/0", regaData, regbData); end
    ex_wr = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic test_load_use();
    ex_is_load = 1'b1; ex_wr = 1'b1; ex_addr = 5'd5; ex_data = 32'hDEAD;
    regaData_i = 32'd50; regbData_i = 32'd60;
    inst = 32'h00A43020; in_valid = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lu_in_ready got %b exp 0", in_ready); end
    step();
    n_vec++; if (out_valid !== 1'b0 || op !== CMD_NONE || regcWr !== 1'b0) begin n_err++; $display("FAIL lu_bubble got %b/%0d/%b exp 0/0/0", out_valid, op, regcWr); end
    n_vec++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_stall got %0d exp 1", stall_cnt); end
    ex_is_load = 1'b0; ex_wr = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lu_release got %b exp 1", in_ready); end
    step(); in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || op !== CMD_ADD || regcAddr !== 5'd6) begin n_err++; $display("FAIL lu_accept got %b/%0d/%0d exp 1/%0d/6", out_valid, op, regcAddr, CMD_ADD); end
    n_vec++; if (regaData !== 32'd50 || regbData !== 32'd60 || stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_data got %0d/%0d/%0d exp 50/60/1", regaData, regbData, stall_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    inst = 32'h34271234; in_valid = 1'b1; regaData_i = 32'd999;
    ex_is_load = 1'b1; ex_wr = 1'b1; ex_addr = 5'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
      step();
      n_vec++; if (out_valid !== 1'b1 || op !== CMD_ADD || regcAddr !== 5'd6 || regaData !== 32'd50 || regbData !== 32'd60) begin
        n_err++; $display("FAIL bp_hold[%0d] got %b/%0d/%0d/%0d/%0d exp 1/%0d/6/50/60", i, out_valid, op, regcAddr, regaData, regbData, CMD_ADD);
      end
      n_vec++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL bp_stall[%0d] got %0d exp 1", i, stall_cnt); end
    end
    ex_is_load = 1'b0; ex_wr = 1'b0; out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got %b exp 1", in_ready); end
    step();
    n_vec++; if (out_valid !== 1'b1 || op !== CMD_ORI || regcAddr !== 5'd7 || regcWr !== 1'b1) begin n_err++; $display("FAIL bp_ori got %b/%0d/%0d/%b exp 1/%0d/7/1", out_valid, op, regcAddr, regcWr, CMD_ORI); end
    n_vec++; if (imm !== 32'h00001234 || regaData !== 32'd999) begin n_err++; $display("FAIL bp_ori_data got %h/%0d exp 00001234/999", imm, regaData); end
  endtask

  task automatic test_illegal();
    inst = 32'hFC000000; in_valid = 1'b1;
    #1;
    n_vec++; if (regaRd !== 1'b0 || regbRd !== 1'b0 || regaAddr !== 5'd0 || regbAddr !== 5'd0) begin n_err++; $display("FAIL ill_rd got %b%b/%0d/%0d exp 00/0/0", regaRd, regbRd, regaAddr, regbAddr); end
    step();
    n_vec++; if (op !== CMD_NONE || illegal !== 1'b1 || regcWr !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL ill_out got %0d/%b/%b/%b exp 0/1/0/1", op, illegal, regcWr, out_valid); end
    inst = 32'h34200005;
    step();
    n_vec++; if (op !== CMD_ORI || regcWr !== 1'b0 || illegal !== 1'b0 || imm !== 32'd5) begin n_err++; $display("FAIL ori_r0 got %0d/%b/%b/%h exp %0d/0/0/5", op, regcWr, illegal, imm, CMD_ORI); end
    inst = 32'h3C05ABCD;
    #1;
    n_vec++; if (regaRd !== 1'b0 || regbRd !== 1'b0) begin n_err++; $display("FAIL lui_rd got %b%b exp 00", regaRd, regbRd); end
    step();
    n_vec++; if (op !== CMD_LUI || imm !== 32'hABCD0000 || regcAddr !== 5'd5 || regcWr !== 1'b1) begin n_err++; $display("FAIL lui got %0d/%h/%0d/%b exp %0d/abcd0000/5/1", op, imm, regcAddr, regcWr, CMD_LUI); end
    inst = 32'hAC220004;
    #1;
    n_vec++; if (regbRd !== 1'b1 || regbAddr !== 5'd2 || regaAddr !== 5'd1) begin n_err++; $display("FAIL sw_rd got %b/%0d/%0d exp 1/2/1", regbRd, regbAddr, regaAddr); end
    step();
    n_vec++; if (op !== CMD_SW || regcWr !== 1'b0) begin n_err++; $display("FAIL sw got %0d/%b exp %0d/0", op, regcWr, CMD_SW); end
    in_valid = 1'b0;
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    inst = 32'h00211820; in_valid = 1'b1;
    step(); in_valid = 1'b0; out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre got %b exp 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || op !== CMD_NONE || stall_cnt !== 16'd0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_rst got %b/%0d/%0d/%b exp 0/0/0/0", out_valid, op, stall_cnt, in_ready);
    end
    step(); rst = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_forwarding();
    test_load_use();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
